// File: rtl/net_pkg.sv
// Shared types and constants for the peer player-state link receiver.
package net_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PKT_BYTES = 6;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] dir;
    logic [3:0] state;
    logic [8:0] x;
    logic [8:0] y;
  } player_pkt_t;

  // Per-slot storage; the id is implied by the slot index.
  typedef struct packed {
    logic [1:0] dir;
    logic [3:0] state;
    logic [8:0] x;
    logic [8:0] y;
  } slot_regs_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} byte_state_e;

  typedef enum logic [2:0] {PK_HUNT, PK_HDR, PK_XL, PK_YL, PK_HI, PK_CHK} pkt_state_e;

  // Peers are packed into consecutive slots by skipping the local ID.
  function automatic logic [1:0] slot_of(input logic [1:0] id, input logic [1:0] local_id);
    return id - {1'b0, (id > local_id)};
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver, LSB first, mid-bit sampling with a down-counter bit timer.
//  state    | meaning
//  RX_IDLE  | line idle, waiting for a low level
//  RX_START | half-bit wait, confirm start bit still low
//  RX_DATA  | sampling 8 data bits at mid-bit
//  RX_STOP  | sampling stop bit; high = byte, low = framing error
module uart_byte_rx
  import net_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk_65mhz,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta_q, rx_q;
  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    case (state_q)
      RX_IDLE: begin
        if (!rx_q) begin
          state_d = RX_START;
          cnt_d   = HALF;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // A high level at mid start bit is a glitch, not an error.
          if (!rx_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          byte_valid = rx_q;
          frame_err  = !rx_q;
          state_d    = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;

  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= serial_in;
      rx_q      <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/remote_player_rx.sv
// Peer player-state packet receiver: unpacks packets into per-slot shadow regs and
// commits them to the outputs on each vsync rising edge.
//  state   | meaning
//  PK_HUNT | discarding bytes until the sync byte
//  PK_HDR  | expecting {id,dir,state}
//  PK_XL   | expecting x[7:0]
//  PK_YL   | expecting y[7:0]
//  PK_HI   | expecting {x[8],y[8],6'b0}
//  PK_CHK  | expecting XOR checksum; accept or reject
module remote_player_rx
  import net_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int STALE_FRAMES = 30
) (
  input  logic       clk_65mhz,
  input  logic       reset,
  input  logic       vsync,
  input  logic       serial_in,
  input  logic [1:0] num_players,
  input  logic [1:0] local_player_ID,
  output logic [8:0] player_a_x,
  output logic [8:0] player_b_x,
  output logic [8:0] player_c_x,
  output logic [8:0] player_a_y,
  output logic [8:0] player_b_y,
  output logic [8:0] player_c_y,
  output logic [1:0] player_a_dir,
  output logic [1:0] player_b_dir,
  output logic [1:0] player_c_dir,
  output logic [3:0] player_a_state,
  output logic [3:0] player_b_state,
  output logic [3:0] player_c_state,
  output logic [2:0] slot_stale,
  output logic       pkt_valid,
  output logic       pkt_error
);

  localparam logic [4:0] STALE_CNT = 5'(STALE_FRAMES);

  logic [7:0]  byte_data;
  logic        byte_valid, frame_err;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk_65mhz (clk_65mhz),
    .reset     (reset),
    .serial_in (serial_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  pkt_state_e  pkt_state_q, pkt_state_d;
  logic [7:0]  hdr_q, hdr_d, xl_q, xl_d, yl_q, yl_d, hi_q, hi_d;
  logic        vsync_q, vsync_rise;
  logic        pkt_valid_q, pkt_valid_d, pkt_error_q, pkt_error_d;
  slot_regs_t  shadow_q [3];
  slot_regs_t  shadow_d [3];
  slot_regs_t  out_q [3];
  slot_regs_t  out_d [3];
  logic [4:0]  stale_cnt_q [3];
  logic [4:0]  stale_cnt_d [3];
  logic [2:0]  stale_q, stale_d;
  player_pkt_t rx_pkt;
  logic [1:0]  rx_slot;
  logic        accept;

  assign vsync_rise = vsync && !vsync_q;

  always_comb begin
    rx_pkt.id    = hdr_q[7:6];
    rx_pkt.dir   = hdr_q[5:4];
    rx_pkt.state = hdr_q[3:0];
    rx_pkt.x     = {hi_q[7], xl_q};
    rx_pkt.y     = {hi_q[6], yl_q};
    rx_slot      = slot_of(rx_pkt.id, local_player_ID);
  end

  always_comb begin
    pkt_state_d = pkt_state_q;
    hdr_d       = hdr_q;
    xl_d        = xl_q;
    yl_d        = yl_q;
    hi_d        = hi_q;
    pkt_valid_d = 1'b0;
    pkt_error_d = 1'b0;
    accept      = 1'b0;
    if (frame_err && pkt_state_q != PK_HUNT) begin
      pkt_error_d = 1'b1;
      pkt_state_d = PK_HUNT;
    end else if (byte_valid) begin
      case (pkt_state_q)
        PK_HUNT: if (byte_data == SYNC_BYTE) pkt_state_d = PK_HDR;
        PK_HDR:  begin hdr_d = byte_data; pkt_state_d = PK_XL;  end
        PK_XL:   begin xl_d  = byte_data; pkt_state_d = PK_YL;  end
        PK_YL:   begin yl_d  = byte_data; pkt_state_d = PK_HI;  end
        PK_HI:   begin hi_d  = byte_data; pkt_state_d = PK_CHK; end
        PK_CHK: begin
          pkt_state_d = PK_HUNT;
          accept = (byte_data == (hdr_q ^ xl_q ^ yl_q ^ hi_q)) &&
                   (rx_pkt.id < num_players) && (rx_pkt.id != local_player_ID);
          pkt_valid_d = accept;
          pkt_error_d = !accept;
        end
        default: pkt_state_d = PK_HUNT;
      endcase
    end
  end

  // Commit takes the pre-update shadow, so a same-cycle accept waits a frame.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      shadow_d[s]    = shadow_q[s];
      out_d[s]       = vsync_rise ? shadow_q[s] : out_q[s];
      stale_cnt_d[s] = stale_cnt_q[s];
      stale_d[s]     = stale_q[s];
      if (accept && rx_slot == 2'(s)) begin
        shadow_d[s].dir   = rx_pkt.dir;
        shadow_d[s].state = rx_pkt.state;
        shadow_d[s].x     = rx_pkt.x;
        shadow_d[s].y     = rx_pkt.y;
        stale_cnt_d[s]    = '0;
      end else if (vsync_rise && stale_cnt_q[s] < STALE_CNT) begin
        stale_cnt_d[s] = stale_cnt_q[s] + 1'b1;
      end
      if (stale_cnt_q[s] == STALE_CNT) stale_d[s] = 1'b1;
      else if (vsync_rise)             stale_d[s] = 1'b0;
    end
  end

  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      pkt_state_q <= PK_HUNT;
      hdr_q       <= '0;
      xl_q        <= '0;
      yl_q        <= '0;
      hi_q        <= '0;
      vsync_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      stale_q     <= 3'b111;
      for (int s = 0; s < 3; s++) begin
        shadow_q[s]    <= '0;
        out_q[s]       <= '0;
        stale_cnt_q[s] <= STALE_CNT;
      end
    end else begin
      pkt_state_q <= pkt_state_d;
      hdr_q       <= hdr_d;
      xl_q        <= xl_d;
      yl_q        <= yl_d;
      hi_q        <= hi_d;
      vsync_q     <= vsync;
      pkt_valid_q <= pkt_valid_d;
      pkt_error_q <= pkt_error_d;
      stale_q     <= stale_d;
      for (int s = 0; s < 3; s++) begin
        shadow_q[s]    <= shadow_d[s];
        out_q[s]       <= out_d[s];
        stale_cnt_q[s] <= stale_cnt_d[s];
      end
    end
  end

  assign player_a_x     = out_q[0].x;
  assign player_b_x     = out_q[1].x;
  assign player_c_x     = out_q[2].x;
  assign player_a_y     = out_q[0].y;
  assign player_b_y     = out_q[1].y;
  assign player_c_y     = out_q[2].y;
  assign player_a_dir   = out_q[0].dir;
  assign player_b_dir   = out_q[1].dir;
  assign player_c_dir   = out_q[2].dir;
  assign player_a_state = out_q[0].state;
  assign player_b_state = out_q[1].state;
  assign player_c_state = out_q[2].state;
  assign slot_stale     = stale_q;
  assign pkt_valid      = pkt_valid_q;
  assign pkt_error      = pkt_error_q;

endmodule

// File: tb/tb_remote_player_rx.sv
// Directed bench for remote_player_rx with a shortened bit time.
module tb_remote_player_rx;
  import net_pkg::*;

  localparam int BIT = 16;

  logic       clk_65mhz = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       serial_in = 1'b1;
  logic [1:0] num_players = 2'd3;
  logic [1:0] local_player_ID = 2'd0;
  logic [8:0] player_a_x, player_b_x, player_c_x;
  logic [8:0] player_a_y, player_b_y, player_c_y;
  logic [1:0] player_a_dir, player_b_dir, player_c_dir;
  logic [3:0] player_a_state, player_b_state, player_c_state;
  logic [2:0] slot_stale;
  logic       pkt_valid, pkt_error;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int error_cnt = 0;
  int v0, e0;

  remote_player_rx #(.CLKS_PER_BIT(BIT), .STALE_FRAMES(30)) dut (
    .clk_65mhz      (clk_65mhz),
    .reset          (reset),
    .vsync          (vsync),
    .serial_in      (serial_in),
    .num_players    (num_players),
    .local_player_ID(local_player_ID),
    .player_a_x     (player_a_x),
    .player_b_x     (player_b_x),
    .player_c_x     (player_c_x),
    .player_a_y     (player_a_y),
    .player_b_y     (player_b_y),
    .player_c_y     (player_c_y),
    .player_a_dir   (player_a_dir),
    .player_b_dir   (player_b_dir),
    .player_c_dir   (player_c_dir),
    .player_a_state (player_a_state),
    .player_b_state (player_b_state),
    .player_c_state (player_c_state),
    .slot_stale     (slot_stale),
    .pkt_valid      (pkt_valid),
    .pkt_error      (pkt_error)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  always @(posedge clk_65mhz) begin
    if (pkt_valid) valid_cnt <= valid_cnt + 1;
    if (pkt_error) error_cnt <= error_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk_65mhz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      clks(BIT);
    end
    serial_in = stop;
    clks(BIT);
    serial_in = 1'b1;
    if (!stop) clks(12 * BIT);
    clks(2);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, xl, yl, hi, chk);
    send_byte(8'hA5, 1'b1);
    send_byte(hdr, 1'b1);
    send_byte(xl, 1'b1);
    send_byte(yl, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(chk, 1'b1);
    clks(4);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    clks(2);
    vsync = 1'b0;
    clks(3);
  endtask

  initial begin
    clks(5);
    reset = 1'b0;
    clks(3);
    check_val("rst_a_x", 32'(player_a_x), 32'd0);
    check_val("rst_stale", 32'(slot_stale), 32'b111);
    check_val("rst_pulses", 32'(valid_cnt + error_cnt), 32'd0);

    // Test 1: id1 -> slot a with local=0
    send_pkt(8'h5B, 8'h40, 8'h20, 8'hC0, 8'hFB);
    check_val("t1_valid", 32'(valid_cnt), 32'd1);
    check_val("t1_err", 32'(error_cnt), 32'd0);
    check_val("t1_pre_commit_x", 32'(player_a_x), 32'd0);
    pulse_vsync();
    check_val("t1_a_x", 32'(player_a_x), 32'd320);
    check_val("t1_a_y", 32'(player_a_y), 32'd288);
    check_val("t1_a_dir", 32'(player_a_dir), 32'd1);
    check_val("t1_a_state", 32'(player_a_state), 32'hB);
    check_val("t1_stale", 32'(slot_stale), 32'b110);

    // Test 2: bad checksum
    send_pkt(8'h5B, 8'h41, 8'h20, 8'hC0, 8'h00);
    check_val("t2_err", 32'(error_cnt), 32'd1);
    check_val("t2_valid", 32'(valid_cnt), 32'd1);

    // Test 3: own ID, then id beyond num_players
    send_pkt(8'h1B, 8'h40, 8'h20, 8'hC0, 8'hBB);
    check_val("t3_own_id_err", 32'(error_cnt), 32'd2);
    num_players = 2'd2;
    send_pkt(8'h9B, 8'h40, 8'h20, 8'hC0, 8'h3B);
    check_val("t3_big_id_err", 32'(error_cnt), 32'd3);
    num_players = 2'd3;
    pulse_vsync();
    check_val("t3_a_x_kept", 32'(player_a_x), 32'd320);
    check_val("t3_b_x_untouched", 32'(player_b_x), 32'd0);
    check_val("t3_valid", 32'(valid_cnt), 32'd1);

    // Test 4: local=1, id0 -> slot a, id2 -> slot b
    local_player_ID = 2'd1;
    send_pkt(8'h23, 8'h10, 8'h11, 8'h00, 8'h22);
    send_pkt(8'hB5, 8'hFF, 8'h05, 8'h80, 8'hCF);
    check_val("t4_valid", 32'(valid_cnt), 32'd3);
    pulse_vsync();
    check_val("t4_a_x", 32'(player_a_x), 32'd16);
    check_val("t4_a_y", 32'(player_a_y), 32'd17);
    check_val("t4_a_dir", 32'(player_a_dir), 32'd2);
    check_val("t4_a_state", 32'(player_a_state), 32'd3);
    check_val("t4_b_x", 32'(player_b_x), 32'd511);
    check_val("t4_b_y", 32'(player_b_y), 32'd5);
    check_val("t4_b_dir", 32'(player_b_dir), 32'd3);
    check_val("t4_b_state", 32'(player_b_state), 32'd5);
    check_val("t4_c_x", 32'(player_c_x), 32'd0);
    check_val("t4_stale", 32'(slot_stale), 32'b100);

    // Test 5: two packets for slot b in one frame, last wins
    send_pkt(8'h81, 8'h22, 8'h33, 8'h00, 8'h90);
    send_pkt(8'h82, 8'h44, 8'h55, 8'h00, 8'h93);
    pulse_vsync();
    check_val("t5_b_x", 32'(player_b_x), 32'h44);
    check_val("t5_b_y", 32'(player_b_y), 32'h55);
    check_val("t5_b_state", 32'(player_b_state), 32'd2);
    check_val("t5_valid", 32'(valid_cnt), 32'd5);

    // Framing error mid-packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h10, 1'b0);
    check_val("frame_err", 32'(error_cnt), 32'd4);
    check_val("frame_no_valid", 32'(valid_cnt), 32'd5);

    // Test 6: stale boundary on slot a
    send_pkt(8'h23, 8'h10, 8'h11, 8'h00, 8'h22);
    repeat (29) pulse_vsync();
    check_val("t6_stale_29", 32'(slot_stale[0]), 32'd0);
    pulse_vsync();
    check_val("t6_stale_30", 32'(slot_stale[0]), 32'd1);
    send_pkt(8'h23, 8'h10, 8'h11, 8'h00, 8'h22);
    check_val("t6_stale_pre_commit", 32'(slot_stale[0]), 32'd1);
    pulse_vsync();
    check_val("t6_stale_cleared", 32'(slot_stale), 32'b110);

    // Reset mid-packet
    v0 = valid_cnt;
    e0 = error_cnt;
    send_byte(8'hA5, 1'b1);
    serial_in = 1'b0;
    clks(3 * BIT);
    reset = 1'b1;
    clks(3);
    serial_in = 1'b1;
    reset = 1'b0;
    clks(15 * BIT);
    check_val("rst2_a_x", 32'(player_a_x), 32'd0);
    check_val("rst2_b_x", 32'(player_b_x), 32'd0);
    check_val("rst2_stale", 32'(slot_stale), 32'b111);
    check_val("rst2_no_pulses", 32'(valid_cnt + error_cnt), 32'(v0 + e0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
